fft_stream_checker: RTL and testbench

Synthesizable output checker for the parallel FFT datapath: compares the multi-lane complex output stream of `topfft` against an expected stream delivered with a fixed latency offset. It aligns the two streams through an internal delay line, flags per-lane mismatches, and tracks frame and beat position. It also counts errors and captures the first failure location. It sits beside `topfft` in BIST/FPGA builds and replaces file-based output comparison. It is generalised over lane count, sample width, FFT size and pipeline latency.

---
 rtl/fft_stream_checker.sv | 208 ++++++++++++++++++++
 tb/tb_fft_stream_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stream_checker.sv
// fft_stream_checker
//
// Checks the multi-lane complex output stream of the parallel FFT against an
// expected stream that arrives LATENCY cycles earlier. The expected stream runs
// through an internal delay line, and each delayed beat is compared lane by lane
// with the DUT beat of the same cycle. The checker tracks beat and frame
// position, counts mismatching lanes (saturating) and captures where the first
// failure happened. If the two streams lose alignment it stops in a sticky
// alignment-error state, which only rst or clear can leave.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   clear_i                synchronous statistics clear (delay line kept)
//   ref_valid_i/ref_data_i expected beat, LATENCY cycles ahead of the DUT
//   dut_valid_i/dut_data_i DUT output beat
//   mismatch_o             per-lane inequality of last compared beat
//   mismatch_valid_o       1-cycle pulse per compared beat
//   beat_index_o           beat position of last compared beat in its frame
//   frame_count_o          completed frames (saturating)
//   err_count_o            total mismatching lanes (saturating)
//   first_err_*_o          sticky capture of the first failing beat
//   align_err_o            high while the checker is in the alignment-error state
module fft_stream_checker #(
    parameter int NBITS_out = 10,
    parameter int LANES     = 4,
    parameter int N         = 128,
    parameter int LATENCY   = 14,
    parameter int CNT_W     = 16,
    localparam int BEATS    = N / LANES,
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int SMP_W    = 2 * NBITS_out,
    localparam int DATA_W   = LANES * SMP_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              ref_valid_i,
    input  logic [DATA_W-1:0] ref_data_i,
    input  logic              dut_valid_i,
    input  logic [DATA_W-1:0] dut_data_i,
    output logic [LANES-1:0]  mismatch_o,
    output logic              mismatch_valid_o,
    output logic [BEAT_W-1:0] beat_index_o,
    output logic [CNT_W-1:0]  frame_count_o,
    output logic [CNT_W-1:0]  err_count_o,
    output logic              first_err_valid_o,
    output logic [CNT_W-1:0]  first_err_frame_o,
    output logic [BEAT_W-1:0] first_err_beat_o,
    output logic [LANE_W-1:0] first_err_lane_o,
    output logic              align_err_o
);

    // Wide enough that err_count + popcount never overflows before saturation.
    localparam int SUM_W = CNT_W + $clog2(LANES + 1) + 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StRun, StAlignErr} state_e;

    state_e state_q, state_d;

    logic              dly_valid_q [LATENCY];
    logic [DATA_W-1:0] dly_data_q  [LATENCY];
    logic              d_valid;
    logic [DATA_W-1:0] d_data;

    logic [LANES-1:0]  mism_q, mism_d;
    logic              mvalid_q, mvalid_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
    logic [CNT_W-1:0]  frame_q, frame_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              fev_q, fev_d;
    logic [CNT_W-1:0]  fef_q, fef_d;
    logic [BEAT_W-1:0] feb_q, feb_d;
    logic [LANE_W-1:0] fel_q, fel_d;

    logic              both_valid, one_valid, compare, beat_wrap;
    logic [LANES-1:0]  lane_diff;
    logic [SUM_W-1:0]  pop, err_sum;
    logic [LANE_W-1:0] low_lane;

    // Delay line: valid bits are reset, data is don't-care while invalid.
    always_ff @(posedge clk_i) begin
        dly_valid_q[0] <= rst_i ? 1'b0 : ref_valid_i;
        dly_data_q[0]  <= ref_data_i;
        for (int i = 1; i < LATENCY; i++) begin
            dly_valid_q[i] <= rst_i ? 1'b0 : dly_valid_q[i-1];
            dly_data_q[i]  <= dly_data_q[i-1];
        end
    end

    assign d_valid = dly_valid_q[LATENCY-1];
    assign d_data  = dly_data_q[LATENCY-1];

    assign both_valid = d_valid & dut_valid_i;
    assign one_valid  = d_valid ^ dut_valid_i;
    assign compare    = both_valid && (state_q != StAlignErr);
    assign beat_wrap  = (beat_q == BEAT_W'(BEATS - 1));

    // Per-lane compare, popcount and lowest mismatching lane.
    always_comb begin
        lane_diff = '0;
        pop       = '0;
        low_lane  = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_diff[k] = (dut_data_i[k*SMP_W +: SMP_W] != d_data[k*SMP_W +: SMP_W]);
            pop          = pop + SUM_W'(lane_diff[k]);
        end
        for (int k = LANES - 1; k >= 0; k--) begin
            if (lane_diff[k]) low_lane = LANE_W'(k);
        end
        err_sum = SUM_W'(err_q) + pop;
    end

    always_comb begin
        state_d    = state_q;
        mism_d     = mism_q;
        mvalid_d   = 1'b0;
        beat_d     = beat_q;
        beat_idx_d = beat_idx_q;
        frame_d    = frame_q;
        err_d      = err_q;
        fev_d      = fev_q;
        fef_d      = fef_q;
        feb_d      = feb_q;
        fel_d      = fel_q;

        case (state_q)
            StIdle, StRun: begin
                if (one_valid)       state_d = StAlignErr;
                else if (both_valid) state_d = StRun;
            end
            StAlignErr: ;
            default:    state_d = StIdle;
        endcase

        if (compare) begin
            mism_d     = lane_diff;
            mvalid_d   = 1'b1;
            beat_idx_d = beat_q;
            beat_d     = beat_wrap ? '0 : beat_q + BEAT_W'(1);
            if (beat_wrap && frame_q != CntMax) frame_d = frame_q + CNT_W'(1);
            err_d = (err_sum > SUM_W'(CntMax)) ? CntMax : err_sum[CNT_W-1:0];
            if ((|lane_diff) && !fev_q) begin
                fev_d = 1'b1;
                fef_d = frame_q;
                feb_d = beat_q;
                fel_d = low_lane;
            end
        end

        // Clear wins over a coincident compare; that beat is dropped.
        if (clear_i) begin
            state_d    = StIdle;
            mism_d     = '0;
            mvalid_d   = 1'b0;
            beat_d     = '0;
            beat_idx_d = '0;
            frame_d    = '0;
            err_d      = '0;
            fev_d      = 1'b0;
            fef_d      = '0;
            feb_d      = '0;
            fel_d      = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            mism_q     <= '0;
            mvalid_q   <= 1'b0;
            beat_q     <= '0;
            beat_idx_q <= '0;
            frame_q    <= '0;
            err_q      <= '0;
            fev_q      <= 1'b0;
            fef_q      <= '0;
            feb_q      <= '0;
            fel_q      <= '0;
        end else begin
            state_q    <= state_d;
            mism_q     <= mism_d;
            mvalid_q   <= mvalid_d;
            beat_q     <= beat_d;
            beat_idx_q <= beat_idx_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            fev_q      <= fev_d;
            fef_q      <= fef_d;
            feb_q      <= feb_d;
            fel_q      <= fel_d;
        end
    end

    assign mismatch_o        = mism_q;
    assign mismatch_valid_o  = mvalid_q;
    assign beat_index_o      = beat_idx_q;
    assign frame_count_o     = frame_q;
    assign err_count_o       = err_q;
    assign first_err_valid_o = fev_q;
    assign first_err_frame_o = fef_q;
    assign first_err_beat_o  = feb_q;
    assign first_err_lane_o  = fel_q;
    assign align_err_o       = (state_q == StAlignErr);

endmodule

// File: tb/tb_fft_stream_checker.sv
// Testbench for fft_stream_checker: table-driven stream scenarios plus
// hand-written clear and reset sequences. A second instance with 4-bit
// counters shares the stimulus and is used for the saturation check.
module tb_fft_stream_checker;

    localparam int NB  = 10;
    localparam int LN  = 4;
    localparam int NP  = 128;
    localparam int LAT = 14;
    localparam int DW  = LN * 2 * NB;

    logic          clk = 1'b0;
    logic          rst, clear, ref_valid, dut_valid;
    logic [DW-1:0] ref_data, dut_data;

    logic [LN-1:0] mm;
    logic          mv, fev, ae;
    logic [4:0]    bi, feb;
    logic [15:0]   fc, ec, fef;
    logic [1:0]    fel;

    logic [LN-1:0] s_mm;
    logic          s_mv, s_fev, s_ae;
    logic [4:0]    s_bi, s_feb;
    logic [3:0]    s_fc, s_ec, s_fef;
    logic [1:0]    s_fel;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int pulses, bad_pulses, last_bad, align_c;

    always #5 clk = ~clk;

    fft_stream_checker #(
        .NBITS_out(NB), .LANES(LN), .N(NP), .LATENCY(LAT), .CNT_W(16)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .ref_valid_i(ref_valid), .ref_data_i(ref_data),
        .dut_valid_i(dut_valid), .dut_data_i(dut_data),
        .mismatch_o(mm), .mismatch_valid_o(mv), .beat_index_o(bi),
        .frame_count_o(fc), .err_count_o(ec), .first_err_valid_o(fev),
        .first_err_frame_o(fef), .first_err_beat_o(feb), .first_err_lane_o(fel),
        .align_err_o(ae)
    );

    fft_stream_checker #(
        .NBITS_out(NB), .LANES(LN), .N(NP), .LATENCY(LAT), .CNT_W(4)
    ) u_sat (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .ref_valid_i(ref_valid), .ref_data_i(ref_data),
        .dut_valid_i(dut_valid), .dut_data_i(dut_data),
        .mismatch_o(s_mm), .mismatch_valid_o(s_mv), .beat_index_o(s_bi),
        .frame_count_o(s_fc), .err_count_o(s_ec), .first_err_valid_o(s_fev),
        .first_err_frame_o(s_fef), .first_err_beat_o(s_feb), .first_err_lane_o(s_fel),
        .align_err_o(s_ae)
    );

    typedef struct {
        int            lat;
        int            nb;
        int            cb;
        int            ncb;
        logic [DW-1:0] mask;
        int            e_err;
        int            e_sat;
        int            e_frame;
        int            e_bi;
        int            e_fev;
        int            e_fef;
        int            e_feb;
        int            e_fel;
        int            e_ae_c;
        int            e_pulses;
        int            e_bad;
        int            e_last;
    } vec_t;

    vec_t tbl[4];

    function automatic logic [DW-1:0] ramp(input int b);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < LN; k++) begin
            r[k*2*NB +: 2*NB] = {NB'(b * LN + k), NB'(b * LN + k + 300)};
        end
        return r;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ref_valid = 1'b0;
        dut_valid = 1'b0;
        clear     = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mismatch"}, mm, 0);
        check({tag, "_mvalid"}, mv, 0);
        check({tag, "_beat_index"}, bi, 0);
        check({tag, "_frame_count"}, fc, 0);
        check({tag, "_err_count"}, ec, 0);
        check({tag, "_fe_valid"}, fev, 0);
        check({tag, "_fe_frame"}, fef, 0);
        check({tag, "_fe_beat"}, feb, 0);
        check({tag, "_fe_lane"}, fel, 0);
        check({tag, "_align_err"}, ae, 0);
    endtask

    // Ref beat b is driven at cycle b, DUT beat b at cycle b+lat.
    // After rst_c the ref stream stops while the DUT stream continues.
    task automatic run(input int lat, input int nb, input int cb, input int ncb,
                       input logic [DW-1:0] cmask, input int clr_c, input int rst_c);
        int last;
        pulses     = 0;
        bad_pulses = 0;
        last_bad   = 0;
        align_c    = -1;
        last       = (rst_c >= 0) ? rst_c + 3 : nb + lat - 1;
        for (int c = 0; c <= last; c++) begin
            int db;
            db        = c - lat;
            ref_valid = (c < nb) && !(rst_c >= 0 && c > rst_c);
            ref_data  = ramp(c);
            dut_valid = (db >= 0) && (db < nb);
            dut_data  = ramp(db);
            if (db >= cb && db < cb + ncb) dut_data = dut_data ^ cmask;
            clear = (c == clr_c);
            rst   = (c == rst_c);
            step();
            if (mv) begin
                pulses++;
                if (mm != 0) begin
                    bad_pulses++;
                    last_bad = int'(mm);
                end
            end
            if (ae && align_c < 0) align_c = c;
            if (c == clr_c) begin
                check("clr_err_count", ec, 0);
                check("clr_mvalid", mv, 0);
                check("clr_align_err", ae, 0);
                check("clr_beat_index", bi, 0);
                check("clr_fe_valid", fev, 0);
            end
            if (c == rst_c) check_all_zero("rst_mid");
        end
        ref_valid = 1'b0;
        dut_valid = 1'b0;
        clear     = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] m_single, m_all;
        m_single     = '0;
        m_single[40] = 1'b1;
        m_all        = '0;
        m_all[0]     = 1'b1;
        m_all[20]    = 1'b1;
        m_all[40]    = 1'b1;
        m_all[60]    = 1'b1;

        //          lat  nb  cb ncb mask      err sat frm bi fev fef feb fel aec pul bad last
        tbl[0] = '{14, 64, -1, 0, '0,       0,  0,  2, 31, 0,  0,  0,  0, -1, 64, 0,  0};
        tbl[1] = '{14, 64, 37, 1, m_single, 1,  1,  2, 31, 1,  1,  5,  2, -1, 64, 1,  4};
        tbl[2] = '{14, 64,  3, 5, m_all,    20, 15, 2, 31, 1,  0,  3,  0, -1, 64, 5,  15};
        tbl[3] = '{13, 64, -1, 0, '0,       0,  0,  0,  0, 0,  0,  0,  0, 13, 0,  0,  0};

        rst       = 1'b1;
        clear     = 1'b0;
        ref_valid = 1'b0;
        dut_valid = 1'b0;
        ref_data  = '0;
        dut_data  = '0;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        for (int i = 0; i < 4; i++) begin
            do_reset();
            run(tbl[i].lat, tbl[i].nb, tbl[i].cb, tbl[i].ncb, tbl[i].mask, -1, -1);
            check($sformatf("v%0d_err_count", i), ec, tbl[i].e_err);
            check($sformatf("v%0d_sat_err_count", i), s_ec, tbl[i].e_sat);
            check($sformatf("v%0d_frame_count", i), fc, tbl[i].e_frame);
            check($sformatf("v%0d_beat_index", i), bi, tbl[i].e_bi);
            check($sformatf("v%0d_fe_valid", i), fev, tbl[i].e_fev);
            check($sformatf("v%0d_fe_frame", i), fef, tbl[i].e_fef);
            check($sformatf("v%0d_fe_beat", i), feb, tbl[i].e_feb);
            check($sformatf("v%0d_fe_lane", i), fel, tbl[i].e_fel);
            check($sformatf("v%0d_align_cycle", i), align_c, tbl[i].e_ae_c);
            check($sformatf("v%0d_pulses", i), pulses, tbl[i].e_pulses);
            check($sformatf("v%0d_bad_pulses", i), bad_pulses, tbl[i].e_bad);
            check($sformatf("v%0d_last_mismatch", i), last_bad, tbl[i].e_last);
        end

        // Alignment error is sticky until clear.
        step();
        check("align_sticky", ae, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("align_after_clear", ae, 0);

        // Clear on the compare cycle of beat 10 (which is corrupted): dropped.
        do_reset();
        run(14, 64, 10, 1, tbl[1].mask >> 20, 24, -1);
        check("clr_end_err_count", ec, 0);
        check("clr_end_fe_valid", fev, 0);
        check("clr_end_frame_count", fc, 1);
        check("clr_end_beat_index", bi, 20);
        check("clr_end_pulses", pulses, 63);
        check("clr_end_align", ae, 0);

        // Reset mid-stream after a corrupted beat; DUT beats continue with no ref.
        do_reset();
        run(14, 64, 2, 1, tbl[2].mask, -1, 30);
        check("rst_end_align_cycle", align_c, 31);
        check("rst_end_err_count", ec, 0);
        check("rst_end_frame_count", fc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
